// File: rtl/prio_encoder_rr.sv
// prio_encoder_rr: N-to-log2(N) priority encoder with a one-deep registered
// output stage and valid/ready handshakes on both sides. RR_MODE selects
// fixed priority (highest index wins) or round-robin arbitration.
//
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   in_valid    in_req is valid this cycle
//   in_ready    block can accept in_req this cycle (combinational)
//   in_req      request vector, bit i = requester i
//   out_valid   out_* fields hold a result
//   out_ready   consumer takes the result this cycle
//   out_idx     encoded index of the granted request
//   out_onehot  one-hot form of out_idx (zero when out_none=1)
//   out_multi   more than one bit of the accepted in_req was set
//   out_none    accepted in_req was all-zero
module prio_encoder_rr #(
   parameter  int unsigned N       = 8,
   parameter  int unsigned RR_MODE = 0,
   localparam int unsigned W       = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_req,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_idx,
   output logic [N-1:0] out_onehot,
   output logic         out_multi,
   output logic         out_none
);

   localparam int unsigned CW = $clog2(N + 1);

   logic [W-1:0]  ptr;
   logic [W-1:0]  grant_c;
   logic [N-1:0]  below_ptr_c;
   logic [N-1:0]  req_hi_c;
   logic [N-1:0]  rr_src_c;
   logic [CW-1:0] count_c;
   logic          accept_c;
   logic          any_req_c;

   // One-deep output register: accept when empty or when being drained.
   assign in_ready  = !out_valid || out_ready;
   assign accept_c  = in_valid && in_ready;
   assign any_req_c = |in_req;

   // Grant selection and popcount.
   always_comb begin
      grant_c     = '0;
      count_c     = '0;
      below_ptr_c = (N'(1) << ptr) - N'(1);
      req_hi_c    = in_req & ~below_ptr_c;
      // Prefer requests at or above ptr; wrap to the whole vector otherwise.
      rr_src_c    = (|req_hi_c) ? req_hi_c : in_req;
      if (RR_MODE != 0) begin
         // Descending scan so the lowest set index is the last assignment.
         for (int i = N - 1; i >= 0; i--) begin
            if (rr_src_c[i]) grant_c = W'(i);
         end
      end else begin
         // Ascending scan so the highest set index wins.
         for (int i = 0; i < N; i++) begin
            if (in_req[i]) grant_c = W'(i);
         end
      end
      for (int i = 0; i < N; i++) begin
         count_c = count_c + CW'(in_req[i]);
      end
   end

   // Output register and round-robin pointer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_idx    <= '0;
         out_onehot <= '0;
         out_multi  <= 1'b0;
         out_none   <= 1'b0;
         ptr        <= '0;
      end else if (accept_c) begin
         out_valid  <= 1'b1;
         out_idx    <= any_req_c ? grant_c : '0;
         out_onehot <= any_req_c ? (N'(1) << grant_c) : '0;
         out_multi  <= (count_c > CW'(1));
         out_none   <= !any_req_c;
         if ((RR_MODE != 0) && any_req_c) begin
            ptr <= (grant_c == W'(N - 1)) ? '0 : grant_c + W'(1);
         end
      end else if (out_ready) begin
         // Drain: data fields keep their last values.
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Bench for prio_encoder_rr: a fixed-priority and a round-robin instance
// (N=4) share one directed stimulus stream; a behavioural model predicts both
// and is compared every cycle, with literal expectations pinning key points.
module tb_prio_encoder_rr;

   localparam int unsigned N = 4;
   localparam int unsigned W = 2;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic [N-1:0] in_req;
   logic         out_ready;

   logic         fx_in_ready, fx_out_valid, fx_out_multi, fx_out_none;
   logic [W-1:0] fx_out_idx;
   logic [N-1:0] fx_out_onehot;
   logic         rr_in_ready, rr_out_valid, rr_out_multi, rr_out_none;
   logic [W-1:0] rr_out_idx;
   logic [N-1:0] rr_out_onehot;

   int errors = 0;
   int checks = 0;

   prio_encoder_rr #(.N(N), .RR_MODE(0)) dut_fx (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(fx_in_ready),
      .in_req(in_req), .out_valid(fx_out_valid), .out_ready(out_ready),
      .out_idx(fx_out_idx), .out_onehot(fx_out_onehot),
      .out_multi(fx_out_multi), .out_none(fx_out_none)
   );

   prio_encoder_rr #(.N(N), .RR_MODE(1)) dut_rr (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rr_in_ready),
      .in_req(in_req), .out_valid(rr_out_valid), .out_ready(out_ready),
      .out_idx(rr_out_idx), .out_onehot(rr_out_onehot),
      .out_multi(rr_out_multi), .out_none(rr_out_none)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model, index 0 = fixed, 1 = round-robin.
   logic         m_ok = 1'b0;
   logic         m_valid [2];
   int           m_idx   [2];
   int           m_oh    [2];
   logic         m_multi [2];
   logic         m_none  [2];
   int           m_ptr;

   function automatic int pick(input int mode, input logic [N-1:0] req, input int p);
      int g;
      g = 0;
      if (mode == 0) begin
         for (int i = 0; i < N; i++) if (req[i]) g = i;
      end else begin
         // Walk from ptr upward with wrap; first set bit wins.
         for (int k = N - 1; k >= 0; k--) if (req[(p + k) % N]) g = (p + k) % N;
      end
      return g;
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         m_ok  = 1'b1;
         m_ptr = 0;
         for (int m = 0; m < 2; m++) begin
            m_valid[m] = 1'b0; m_idx[m] = 0; m_oh[m] = 0;
            m_multi[m] = 1'b0; m_none[m] = 1'b0;
         end
      end else if (m_ok) begin
         for (int m = 0; m < 2; m++) begin
            int  g;
            logic acc;
            acc = in_valid && (!m_valid[m] || out_ready);
            if (acc) begin
               g = pick(m, in_req, m_ptr);
               m_valid[m] = 1'b1;
               m_none[m]  = (in_req == '0);
               m_idx[m]   = (in_req == '0) ? 0 : g;
               m_oh[m]    = (in_req == '0) ? 0 : (1 << g);
               m_multi[m] = ($countones(in_req) > 1);
               if (m == 1 && in_req != '0) m_ptr = (g + 1) % N;
            end else if (m_valid[m] && out_ready) begin
               m_valid[m] = 1'b0;
            end
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (m_ok) begin
         chk("fx_valid",  32'(fx_out_valid),  32'(m_valid[0]));
         chk("fx_idx",    32'(fx_out_idx),    32'(m_idx[0]));
         chk("fx_onehot", 32'(fx_out_onehot), 32'(m_oh[0]));
         chk("fx_multi",  32'(fx_out_multi),  32'(m_multi[0]));
         chk("fx_none",   32'(fx_out_none),   32'(m_none[0]));
         chk("fx_ready",  32'(fx_in_ready),   32'(!m_valid[0] || out_ready));
         chk("rr_valid",  32'(rr_out_valid),  32'(m_valid[1]));
         chk("rr_idx",    32'(rr_out_idx),    32'(m_idx[1]));
         chk("rr_onehot", 32'(rr_out_onehot), 32'(m_oh[1]));
         chk("rr_multi",  32'(rr_out_multi),  32'(m_multi[1]));
         chk("rr_none",   32'(rr_out_none),   32'(m_none[1]));
         chk("rr_ready",  32'(rr_in_ready),   32'(!m_valid[1] || out_ready));
         chk("rr_ptr",    32'(dut_rr.ptr),    32'(m_ptr));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [N-1:0] r, input logic rdy);
      #1;
      in_valid  = v;
      in_req    = r;
      out_ready = rdy;
   endtask

   logic [N-1:0] mix_req [8] = '{4'b0110, 4'b1111, 4'b0000, 4'b1001,
                                 4'b0010, 4'b1100, 4'b0101, 4'b1000};
   logic         mix_rdy [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_req = '0; out_ready = 1'b1;
      tick(); tick();
      chk("lit_reset_valid", 32'(fx_out_valid), 32'd0);
      chk("lit_reset_idx",   32'(rr_out_idx),   32'd0);
      chk("lit_reset_ptr",   32'(dut_rr.ptr),   32'd0);
      rst_n = 1'b1;

      // Fixed grant on 1010 and RR rotation from reset.
      drive(1'b1, 4'b1010, 1'b1);
      tick();
      chk("lit_fx_idx",    32'(fx_out_idx),    32'd3);
      chk("lit_fx_onehot", 32'(fx_out_onehot), 32'b1000);
      chk("lit_fx_multi",  32'(fx_out_multi),  32'd1);
      chk("lit_rr_idx1",   32'(rr_out_idx),    32'd1);
      chk("lit_rr_ptr1",   32'(dut_rr.ptr),    32'd2);
      tick();
      chk("lit_rr_idx2",   32'(rr_out_idx),    32'd3);
      chk("lit_rr_ptr2",   32'(dut_rr.ptr),    32'd0);
      tick();
      chk("lit_rr_idx3",   32'(rr_out_idx),    32'd1);
      chk("lit_rr_ptr3",   32'(dut_rr.ptr),    32'd2);

      // Zero vector with ptr=2.
      drive(1'b1, 4'b0000, 1'b1);
      tick();
      chk("lit_zero_none",   32'(rr_out_none),   32'd1);
      chk("lit_zero_idx",    32'(rr_out_idx),    32'd0);
      chk("lit_zero_onehot", 32'(rr_out_onehot), 32'd0);
      chk("lit_zero_ptr",    32'(dut_rr.ptr),    32'd2);

      // Streaming, fixed mode.
      drive(1'b1, 4'b0001, 1'b1); tick();
      chk("lit_stream0", 32'(fx_out_idx), 32'd0);
      drive(1'b1, 4'b0100, 1'b1); tick();
      chk("lit_stream1", 32'(fx_out_idx), 32'd2);
      drive(1'b1, 4'b1000, 1'b1); tick();
      chk("lit_stream2", 32'(fx_out_idx), 32'd3);
      chk("lit_stream_valid", 32'(fx_out_valid), 32'd1);

      // Backpressure: result idx=3 held for three cycles.
      drive(1'b1, 4'b0110, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("lit_bp_idx",   32'(fx_out_idx),  32'd3);
         chk("lit_bp_ready", 32'(fx_in_ready), 32'd0);
      end
      drive(1'b1, 4'b0110, 1'b1);
      tick();
      chk("lit_bp_new_idx",   32'(fx_out_idx),   32'd2);
      chk("lit_bp_new_multi", 32'(fx_out_multi), 32'd1);
      drive(1'b0, 4'b0110, 1'b1);
      tick();
      chk("lit_drain_valid", 32'(fx_out_valid), 32'd0);
      chk("lit_drain_idx",   32'(fx_out_idx),   32'd2);

      // Reset while a result is stalled.
      drive(1'b1, 4'b1010, 1'b0);
      tick(); tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("lit_rst_valid", 32'(rr_out_valid), 32'd0);
      chk("lit_rst_idx",   32'(fx_out_idx),   32'd0);
      chk("lit_rst_ptr",   32'(dut_rr.ptr),   32'd0);
      chk("lit_rst_ready", 32'(rr_in_ready),  32'd1);

      // Mixed vectors and backpressure, checked by the model.
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, mix_req[i], mix_rdy[i]);
         tick();
      end
      drive(1'b0, 4'b0000, 1'b1);
      tick(); tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
